// File: rtl/multislope_ctrl_if.sv
// Control and result bundle between the multi-slope sequencer, its requester and the pwmgen block.
// The slave modport is the sequencer side; the master modport is the requester/pwmgen side.
interface multislope_ctrl_if;
   logic        convert;
   logic        abort;
   logic        comp;
   logic [31:0] mode_a_in;
   logic [31:0] mode_b_in;
   logic        pwm_start;
   logic        pwm_enable;
   logic        pwm_mode;
   logic        rundown_p;
   logic        rundown_n;
   logic        busy;
   logic [31:0] res_a;
   logic [31:0] res_b;
   logic [15:0] res_rd;
   logic        res_sign;
   logic        res_timeout;
   logic        result_valid;

   modport slave (
      input  convert, abort, comp, mode_a_in, mode_b_in,
      output pwm_start, pwm_enable, pwm_mode, rundown_p, rundown_n, busy,
             res_a, res_b, res_rd, res_sign, res_timeout, result_valid
   );

   modport master (
      output convert, abort, comp, mode_a_in, mode_b_in,
      input  pwm_start, pwm_enable, pwm_mode, rundown_p, rundown_n, busy,
             res_a, res_b, res_rd, res_sign, res_timeout, result_valid
   );
endinterface

// File: rtl/multislope_ctrl.sv
// Multi-slope ADC conversion sequencer: comparator-driven run-up via pwmgen, then a timed
// single-slope run-down; all outputs registered, one result_valid pulse per completed conversion.
module multislope_ctrl #(
   parameter logic [9:0]  PERIOD        = 10'd259,
   parameter logic [15:0] RUNUP_PERIODS = 16'd1000,
   parameter logic [15:0] RUNDOWN_MAX   = 16'd4095
) (
   input  logic             clk,
   input  logic             rst,
   multislope_ctrl_if.slave bus
);
   typedef enum logic [2:0] {
      ST_IDLE, ST_CLEAR, ST_RUNUP, ST_CAPTURE, ST_RUNDOWN, ST_DONE
   } state_t;

   state_t      state_q, state_d;
   logic        comp_m_q, comp_m_d, comp_s_q, comp_s_d;
   logic [9:0]  ph_q, ph_d;
   logic [15:0] np_q, np_d, rd_q, rd_d;
   logic        pwm_start_q, pwm_start_d, pwm_enable_q, pwm_enable_d, pwm_mode_q, pwm_mode_d;
   logic        rundown_p_q, rundown_p_d, rundown_n_q, rundown_n_d;
   logic        busy_q, busy_d, result_valid_q, result_valid_d;
   logic [31:0] res_a_q, res_a_d, res_b_q, res_b_d;
   logic [15:0] res_rd_q, res_rd_d;
   logic        res_sign_q, res_sign_d, res_timeout_q, res_timeout_d;

   always_comb begin
      state_d        = state_q;
      comp_m_d       = bus.comp;
      comp_s_d       = comp_m_q;
      np_d           = np_q;
      rd_d           = rd_q;
      pwm_start_d    = pwm_start_q;
      pwm_enable_d   = pwm_enable_q;
      pwm_mode_d     = pwm_mode_q;
      rundown_p_d    = rundown_p_q;
      rundown_n_d    = rundown_n_q;
      busy_d         = busy_q;
      result_valid_d = 1'b0;
      res_a_d        = res_a_q;
      res_b_d        = res_b_q;
      res_rd_d       = res_rd_q;
      res_sign_d     = res_sign_q;
      res_timeout_d  = res_timeout_q;

      case (state_q)
         ST_IDLE: begin
            busy_d = 1'b0;
            if (bus.convert) begin
               state_d     = ST_CLEAR;
               pwm_start_d = 1'b1;
               pwm_mode_d  = comp_s_q;
            end
         end
         ST_CLEAR: begin
            pwm_start_d  = 1'b0;
            pwm_enable_d = 1'b1;
            np_d         = '0;
            busy_d       = 1'b1;
            state_d      = ST_RUNUP;
         end
         ST_RUNUP: begin
            // Mode changes on the last phase so it is settled when pwmgen sits at count 0.
            if (ph_q == PERIOD) begin
               pwm_mode_d = comp_s_q;
               np_d       = np_q + 16'd1;
               if (np_q == RUNUP_PERIODS - 16'd1) begin
                  pwm_enable_d = 1'b0;
                  state_d      = ST_CAPTURE;
               end
            end
         end
         ST_CAPTURE: begin
            res_a_d     = bus.mode_a_in;
            res_b_d     = bus.mode_b_in;
            res_sign_d  = comp_s_q;
            rd_d        = '0;
            rundown_n_d = comp_s_q;
            rundown_p_d = ~comp_s_q;
            state_d     = ST_RUNDOWN;
         end
         ST_RUNDOWN: begin
            rd_d = rd_q + 16'd1;
            if (comp_s_q != res_sign_q) begin
               res_rd_d      = rd_q;
               res_timeout_d = 1'b0;
               rundown_p_d   = 1'b0;
               rundown_n_d   = 1'b0;
               state_d       = ST_DONE;
            end else if (rd_q == RUNDOWN_MAX) begin
               res_rd_d      = RUNDOWN_MAX;
               res_timeout_d = 1'b1;
               rundown_p_d   = 1'b0;
               rundown_n_d   = 1'b0;
               state_d       = ST_DONE;
            end
         end
         ST_DONE: begin
            result_valid_d = 1'b1;
            busy_d         = 1'b0;
            state_d        = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Abort discards anything this cycle would have captured; earlier results survive.
      if (bus.abort && (state_q != ST_IDLE)) begin
         state_d        = ST_IDLE;
         pwm_enable_d   = 1'b0;
         pwm_start_d    = 1'b0;
         rundown_p_d    = 1'b0;
         rundown_n_d    = 1'b0;
         busy_d         = 1'b0;
         result_valid_d = 1'b0;
         res_a_d        = res_a_q;
         res_b_d        = res_b_q;
         res_rd_d       = res_rd_q;
         res_sign_d     = res_sign_q;
         res_timeout_d  = res_timeout_q;
      end

      if (!pwm_enable_q || !pwm_enable_d) begin
         ph_d = '0;
      end else if (ph_q == PERIOD) begin
         ph_d = '0;
      end else begin
         ph_d = ph_q + 10'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         comp_m_q       <= 1'b0;
         comp_s_q       <= 1'b0;
         ph_q           <= '0;
         np_q           <= '0;
         rd_q           <= '0;
         pwm_start_q    <= 1'b0;
         pwm_enable_q   <= 1'b0;
         pwm_mode_q     <= 1'b0;
         rundown_p_q    <= 1'b0;
         rundown_n_q    <= 1'b0;
         busy_q         <= 1'b0;
         result_valid_q <= 1'b0;
         res_a_q        <= '0;
         res_b_q        <= '0;
         res_rd_q       <= '0;
         res_sign_q     <= 1'b0;
         res_timeout_q  <= 1'b0;
      end else begin
         state_q        <= state_d;
         comp_m_q       <= comp_m_d;
         comp_s_q       <= comp_s_d;
         ph_q           <= ph_d;
         np_q           <= np_d;
         rd_q           <= rd_d;
         pwm_start_q    <= pwm_start_d;
         pwm_enable_q   <= pwm_enable_d;
         pwm_mode_q     <= pwm_mode_d;
         rundown_p_q    <= rundown_p_d;
         rundown_n_q    <= rundown_n_d;
         busy_q         <= busy_d;
         result_valid_q <= result_valid_d;
         res_a_q        <= res_a_d;
         res_b_q        <= res_b_d;
         res_rd_q       <= res_rd_d;
         res_sign_q     <= res_sign_d;
         res_timeout_q  <= res_timeout_d;
      end
   end

   assign bus.pwm_start    = pwm_start_q;
   assign bus.pwm_enable   = pwm_enable_q;
   assign bus.pwm_mode     = pwm_mode_q;
   assign bus.rundown_p    = rundown_p_q;
   assign bus.rundown_n    = rundown_n_q;
   assign bus.busy         = busy_q;
   assign bus.res_a        = res_a_q;
   assign bus.res_b        = res_b_q;
   assign bus.res_rd       = res_rd_q;
   assign bus.res_sign     = res_sign_q;
   assign bus.res_timeout  = res_timeout_q;
   assign bus.result_valid = result_valid_q;
endmodule
